// File: rtl/cpu_sequencer_pkg.sv
// Shared constants and control bundle for the
// multi-cycle mini-CPU sequencer.
package cpu_sequencer_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FUN_ADD  = 6'b100000;
  localparam logic [3:0] ALU_ADD  = 4'b0010;

  localparam logic [2:0] S_IF    = 3'd0;
  localparam logic [2:0] S_ID    = 3'd1;
  localparam logic [2:0] S_EX    = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_WB    = 3'd4;
  localparam logic [2:0] S_FAULT = 3'd7;

  typedef struct packed {
    logic       wr;
    logic       m2r;
    logic [3:0] alu;
    logic       aluimm;
    logic       regrt;
    logic       is_lw;
    logic       is_sw;
  } ctrl_t;

endpackage

// File: rtl/cpu_sequencer_if.sv
// Sequencer <-> memories/IR/datapath bundle.
// master = sequencer, slave = surrounding system.
interface cpu_sequencer_if #(
  parameter int CNT_W = 32
);
  logic [5:0]       opcode;
  logic [5:0]       fun;
  logic             imem_ack;
  logic             dmem_ack;
  logic             imem_req;
  logic             dmem_req;
  logic             dmem_we;
  logic             ir_we;
  logic             pc_we;
  logic             writereg;
  logic             memory2reg;
  logic [3:0]       ALUcontrol;
  logic             ALUImm;
  logic             regrt;
  logic [2:0]       state;
  logic             illegal;
  logic             timeout;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  opcode, fun, imem_ack, dmem_ack,
    output imem_req, dmem_req, dmem_we,
    output ir_we, pc_we, writereg,
    output memory2reg, ALUcontrol, ALUImm,
    output regrt, state, illegal, timeout,
    output instr_count
  );

  modport slave (
    output opcode, fun, imem_ack, dmem_ack,
    input  imem_req, dmem_req, dmem_we,
    input  ir_we, pc_we, writereg,
    input  memory2reg, ALUcontrol, ALUImm,
    input  regrt, state, illegal, timeout,
    input  instr_count
  );

endinterface

// File: rtl/cpu_sequencer_instr_decoder.sv
// Combinational opcode/fun decode into the
// control bundle plus a legal-instruction bit.
module cpu_sequencer_instr_decoder
  import cpu_sequencer_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] fun_i,
  output ctrl_t      ctrl_o,
  output logic       legal_o
);

  logic is_add;
  logic is_lw;
  logic is_sw;

  assign is_add = (opcode_i == OP_RTYPE)
               && (fun_i == FUN_ADD);
  assign is_lw  = (opcode_i == OP_LW);
  assign is_sw  = (opcode_i == OP_SW);

  // one-hot instruction class to control bundle
  always_comb begin
    ctrl_o  = '0;
    legal_o = 1'b0;
    unique case (1'b1)
      is_add: begin
        legal_o    = 1'b1;
        ctrl_o.wr  = 1'b1;
        ctrl_o.alu = ALU_ADD;
      end
      is_lw: begin
        legal_o       = 1'b1;
        ctrl_o.wr     = 1'b1;
        ctrl_o.m2r    = 1'b1;
        ctrl_o.alu    = ALU_ADD;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.is_lw  = 1'b1;
      end
      is_sw: begin
        legal_o       = 1'b1;
        ctrl_o.alu    = ALU_ADD;
        ctrl_o.aluimm = 1'b1;
        ctrl_o.regrt  = 1'b1;
        ctrl_o.is_sw  = 1'b1;
      end
      default: begin
        legal_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// IF/ID/EX/MEM/WB multi-cycle sequencer with
// memory-ack timeout, retire counter and fault trap.
module cpu_sequencer
  import cpu_sequencer_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input logic      clk,
  input logic      rst,
  cpu_sequencer_if.master bus
);

  localparam int WW = $clog2(MEM_TIMEOUT);
  localparam logic [WW-1:0] WLAST =
    WW'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q, state_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ill_q, ill_d;
  logic             to_q, to_d;
  ctrl_t            dec_q, dec_d;
  ctrl_t            dec_c;
  logic             legal_c;
  logic             tmo_c;
  logic             retire_c;
  logic             waiting_c;

  cpu_sequencer_instr_decoder u_dec (
    .opcode_i (bus.opcode),
    .fun_i    (bus.fun),
    .ctrl_o   (dec_c),
    .legal_o  (legal_c)
  );

  assign tmo_c = (wait_q == WLAST);

  // next state, sticky flags, decode capture
  always_comb begin
    state_d  = state_q;
    ill_d    = ill_q;
    to_d     = to_q;
    dec_d    = dec_q;
    retire_c = 1'b0;
    case (state_q)
      S_IF: begin
        if (bus.imem_ack) begin
          state_d = S_ID;
        end else if (tmo_c) begin
          state_d = S_FAULT;
          to_d    = 1'b1;
        end
      end
      S_ID: begin
        dec_d = dec_c;
        if (legal_c) begin
          state_d = S_EX;
        end else begin
          state_d = S_FAULT;
          ill_d   = 1'b1;
        end
      end
      S_EX: begin
        if (dec_q.is_lw || dec_q.is_sw)
          state_d = S_MEM;
        else
          state_d = S_WB;
      end
      S_MEM: begin
        if (bus.dmem_ack) begin
          if (dec_q.is_sw) begin
            state_d  = S_IF;
            retire_c = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (tmo_c) begin
          state_d = S_FAULT;
          to_d    = 1'b1;
        end
      end
      S_WB: begin
        state_d  = S_IF;
        retire_c = 1'b1;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase
  end

  // wait counter restarts on every state entry
  always_comb begin
    waiting_c = (state_q == S_IF)
             || (state_q == S_MEM);
    if (state_d != state_q)
      wait_d = '0;
    else if (waiting_c)
      wait_d = wait_q + 1'b1;
    else
      wait_d = '0;
    cnt_d = retire_c ? cnt_q + 1'b1 : cnt_q;
  end

  // state registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IF;
      wait_q  <= '0;
      cnt_q   <= '0;
      ill_q   <= 1'b0;
      to_q    <= 1'b0;
      dec_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_d;
      ill_q   <= ill_d;
      to_q    <= to_d;
      dec_q   <= dec_d;
    end
  end

  // strobes decoded from state, forced low in reset
  always_comb begin
    bus.imem_req = !rst && (state_q == S_IF);
    bus.ir_we    = bus.imem_req && bus.imem_ack;
    bus.dmem_req = !rst && (state_q == S_MEM);
    bus.dmem_we  = bus.dmem_req && dec_q.is_sw;
    bus.pc_we    = !rst && ((state_q == S_WB)
                || (bus.dmem_req && dec_q.is_sw
                    && bus.dmem_ack));
    bus.writereg = !rst && (state_q == S_WB)
                && dec_q.wr;
  end

  assign bus.memory2reg  = dec_q.m2r;
  assign bus.ALUcontrol  = dec_q.alu;
  assign bus.ALUImm      = dec_q.aluimm;
  assign bus.regrt       = dec_q.regrt;
  assign bus.state       = state_q;
  assign bus.illegal     = ill_q;
  assign bus.timeout     = to_q;
  assign bus.instr_count = cnt_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Randomized bench: per-instruction expected
// cycle traces built from the sequencing rules.
module tb_cpu_sequencer;

  localparam int T  = 4;
  localparam int CW = 4;
  localparam int MOD = 1 << CW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  cpu_sequencer_if #(.CNT_W(CW)) bus ();

  cpu_sequencer #(
    .CNT_W       (CW),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0] st;
    bit ia, da;
    bit ireq, dreq, dwe, irwe, pcwe, wr;
    bit ill, to;
    int cnt;
    bit dchk, m2r, aimm, rrt;
  } exp_t;

  exp_t q[$];
  bit   ill_m, to_m;
  int   cnt_m;
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t got=%0h exp=%0h",
               tag, $time, act, exp);
    end
  endtask

  function automatic exp_t mk(logic [2:0] s);
    exp_t e;
    e = '{default: 0};
    e.st  = s;
    e.ill = ill_m;
    e.to  = to_m;
    e.cnt = cnt_m;
    return e;
  endfunction

  function automatic exp_t setdec(exp_t ei,
                                  bit lw, bit sw);
    exp_t e;
    e = ei;
    e.dchk = 1;
    e.m2r  = lw;
    e.aimm = lw | sw;
    e.rrt  = lw | sw;
    return e;
  endfunction

  task automatic add_fault(input int nf);
    for (int i = 0; i < nf; i++)
      q.push_back(mk(3'd7));
  endtask

  // expected cycle trace of one instruction
  task automatic build(input logic [5:0] op,
                       input logic [5:0] fn,
                       input int di, input int dd,
                       input bit abort,
                       input int nf);
    exp_t e;
    bit lw, sw, add;
    lw  = (op == 6'b100011);
    sw  = (op == 6'b101011);
    add = (op == 6'b000000) && (fn == 6'b100000);
    q.delete();
    for (int k = 0; k < T && k <= di; k++) begin
      e = mk(3'd0);
      e.ireq = 1;
      if (k == di) begin
        e.ia   = 1;
        e.irwe = 1;
      end
      q.push_back(e);
    end
    if (di >= T) begin
      to_m = 1;
      add_fault(nf);
      return;
    end
    q.push_back(mk(3'd1));
    if (!(lw | sw | add)) begin
      ill_m = 1;
      add_fault(nf);
      return;
    end
    q.push_back(setdec(mk(3'd2), lw, sw));
    if (lw | sw) begin
      for (int k = 0; k < T && k <= dd; k++) begin
        e = setdec(mk(3'd3), lw, sw);
        e.dreq = 1;
        e.dwe  = sw;
        if (k == dd) begin
          e.da   = 1;
          e.pcwe = sw;
        end
        q.push_back(e);
        if (abort && k == 1) return;
      end
      if (dd >= T) begin
        to_m = 1;
        add_fault(nf);
        return;
      end
      if (sw) begin
        cnt_m = (cnt_m + 1) % MOD;
        return;
      end
    end
    e = setdec(mk(3'd4), lw, sw);
    e.wr   = 1;
    e.pcwe = 1;
    q.push_back(e);
    cnt_m = (cnt_m + 1) % MOD;
  endtask

  task automatic play();
    foreach (q[i]) begin
      bus.imem_ack = q[i].ia;
      bus.dmem_ack = q[i].da;
      @(negedge clk);
      chk("state", 32'(bus.state), 32'(q[i].st));
      chk("imem_req", 32'(bus.imem_req),
          32'(q[i].ireq));
      chk("dmem_req", 32'(bus.dmem_req),
          32'(q[i].dreq));
      chk("dmem_we", 32'(bus.dmem_we),
          32'(q[i].dwe));
      chk("ir_we", 32'(bus.ir_we), 32'(q[i].irwe));
      chk("pc_we", 32'(bus.pc_we), 32'(q[i].pcwe));
      chk("writereg", 32'(bus.writereg),
          32'(q[i].wr));
      chk("illegal", 32'(bus.illegal),
          32'(q[i].ill));
      chk("timeout", 32'(bus.timeout),
          32'(q[i].to));
      chk("count", 32'(bus.instr_count),
          32'(q[i].cnt));
      if (q[i].dchk) begin
        chk("mem2reg", 32'(bus.memory2reg),
            32'(q[i].m2r));
        chk("aluimm", 32'(bus.ALUImm),
            32'(q[i].aimm));
        chk("regrt", 32'(bus.regrt),
            32'(q[i].rrt));
        chk("aluctl", 32'(bus.ALUcontrol),
            32'h2);
      end
      @(posedge clk);
      #1;
    end
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("rst_ireq", 32'(bus.imem_req), 0);
    chk("rst_dreq", 32'(bus.dmem_req), 0);
    chk("rst_pcwe", 32'(bus.pc_we), 0);
    chk("rst_wr", 32'(bus.writereg), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ill_m = 0;
    to_m  = 0;
    cnt_m = 0;
    chk("rst_state", 32'(bus.state), 0);
    chk("rst_cnt", 32'(bus.instr_count), 0);
  endtask

  task automatic run(input logic [5:0] op,
                     input logic [5:0] fn,
                     input int di, input int dd,
                     input bit abort, input int nf);
    bus.opcode = op;
    bus.fun    = fn;
    build(op, fn, di, dd, abort, nf);
    play();
    if (abort || q[q.size()-1].st == 3'd7)
      do_reset();
  endtask

  localparam logic [5:0] ADD = 6'b000000;
  localparam logic [5:0] FA  = 6'b100000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;

  initial begin
    logic [5:0] op, fn;
    int r, di, dd;
    rst = 1'b1;
    bus.opcode   = '0;
    bus.fun      = '0;
    bus.imem_ack = 1'b0;
    bus.dmem_ack = 1'b0;
    do_reset();
    run(ADD, FA, 0, 0, 0, 1);
    run(LW, 6'h15, 0, 3, 0, 1);
    run(SW, 6'h3f, 0, 0, 0, 1);
    run(6'b000010, 6'h00, 0, 0, 0, 20);
    run(ADD, FA, T, 0, 0, 3);
    run(ADD, FA, T - 1, 0, 0, 1);
    run(LW, 6'h00, T - 1, T, 0, 2);
    run(LW, 6'h00, 1, 10, 1, 0);
    for (int i = 0; i < 17; i++)
      run(ADD, FA, $urandom_range(0, 2), 0, 0, 1);
    chk("wrap", 32'(bus.instr_count), 1);
    for (int i = 0; i < 80; i++) begin
      r  = $urandom_range(0, 9);
      fn = 6'($urandom);
      if (r < 3) begin
        op = ADD;
        fn = FA;
      end else if (r < 6) begin
        op = LW;
      end else if (r < 9) begin
        op = SW;
      end else if ($urandom_range(0, 1) == 0) begin
        op = ADD;
        if (fn == FA) fn = 6'b100010;
      end else begin
        op = 6'($urandom);
        if (op == ADD || op == LW || op == SW)
          op = 6'b111111;
      end
      di = ($urandom_range(0, 7) == 0) ? T
         : $urandom_range(0, T - 1);
      dd = ($urandom_range(0, 7) == 0) ? T
         : $urandom_range(0, T - 1);
      run(op, fn, di, dd, 0, $urandom_range(1, 3));
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
